// File: rtl/apb_reg_pkg.sv
// APB register front end: shared state encoding, bus widths
// and the byte-strobe merge used to build register write data.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  function automatic logic [APB_DATA_W-1:0] byte_merge(
    input logic [APB_DATA_W-1:0] wdata,
    input logic [APB_STRB_W-1:0] strb,
    input logic [APB_DATA_W-1:0] cur
  );
    logic [APB_DATA_W-1:0] m;
    for (int b = 0; b < APB_STRB_W; b++) begin
      m[8*b +: 8] = strb[b] ? wdata[8*b +: 8]
                            : cur[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_reg_frontend_decode.sv
// Byte address to register index decode with range,
// alignment and read-only flags.
module reg_index_decode
  import apb_reg_pkg::*;
#(
  parameter int                  NUM_REGS  = 16,
  parameter int                  ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] paddr,
  output logic [IDX_W-1:0]  index,
  output logic              in_range,
  output logic              misaligned,
  output logic              ro_hit
);

  localparam logic [ADDR_W-3:0] NREG = (ADDR_W-2)'(NUM_REGS);

  logic [ADDR_W-3:0] w_word;

  // BASE_ADDR is word aligned, so only word bits take part
  assign w_word     = paddr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
  assign misaligned = |paddr[1:0];
  assign in_range   = (paddr >= BASE_ADDR) && (w_word < NREG);
  assign index      = w_word[IDX_W-1:0];
  assign ro_hit     = in_range && RO_MASK[index];

endmodule

// File: rtl/apb_reg_frontend.sv
// APB3/APB4 slave front end: one-hot register write strobes,
// merged write data and registered read-back mux.
module apb_reg_frontend
  import apb_reg_pkg::*;
#(
  parameter int                  NUM_REGS  = 16,
  parameter int                  ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter int                  RD_WAIT   = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_W-1:0]              paddr,
  input  logic [APB_DATA_W-1:0]          pwdata,
  input  logic [APB_STRB_W-1:0]          pstrb,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*APB_DATA_W-1:0] reg_cur,
  input  logic [NUM_REGS*APB_DATA_W-1:0] reg_rdata,
  output logic [NUM_REGS-1:0]            reg_wr,
  output logic [APB_DATA_W-1:0]          reg_wdata
);

  localparam logic [2:0] WAIT_N = 3'(RD_WAIT);

  state_e                r_state;
  state_e                w_next;
  logic [2:0]            r_cnt;
  logic                  r_write;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [APB_DATA_W-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [NUM_REGS-1:0]   r_wr;
  logic [APB_DATA_W-1:0] r_wdata;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_misal;
  logic                  w_ro_hit;
  logic                  w_setup;
  logic                  w_err;
  logic                  w_a_write;
  logic                  w_a_err;
  logic [IDX_W-1:0]      w_a_idx;
  logic [APB_DATA_W-1:0] w_cur_a [NUM_REGS];
  logic [APB_DATA_W-1:0] w_rd_a  [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_split
    assign w_cur_a[i] = reg_cur[APB_DATA_W*i +: APB_DATA_W];
    assign w_rd_a[i]  = reg_rdata[APB_DATA_W*i +: APB_DATA_W];
  end

  reg_index_decode #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_dec (
    .paddr      (paddr),
    .index      (w_idx),
    .in_range   (w_in_range),
    .misaligned (w_misal),
    .ro_hit     (w_ro_hit)
  );

  assign w_setup = psel & ~penable;
  assign w_err   = w_misal | ~w_in_range | (pwrite & w_ro_hit);

  // Entering ACCESS straight from IDLE uses the live decode
  assign w_a_write = (r_state == IDLE) ? pwrite : r_write;
  assign w_a_err   = (r_state == IDLE) ? w_err  : r_err;
  assign w_a_idx   = (r_state == IDLE) ? w_idx  : r_idx;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_setup)
          w_next = (pwrite || WAIT_N == 3'd0) ? ACCESS : WAIT;
      end
      WAIT: begin
        if (!psel)              w_next = IDLE;
        else if (r_cnt == 3'd1) w_next = ACCESS;
      end
      ACCESS:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_wr      <= '0;
      r_wdata   <= '0;
    end else begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_wr      <= '0;
      if (r_state == IDLE && w_setup) begin
        r_write <= pwrite;
        r_err   <= w_err;
        r_idx   <= w_idx;
        r_cnt   <= WAIT_N;
        if (pwrite && !w_err)
          r_wdata <= byte_merge(pwdata, pstrb, w_cur_a[w_idx]);
      end
      if (r_state == WAIT)
        r_cnt <= r_cnt - 3'd1;
      if (w_next == ACCESS) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_a_err;
        if (w_a_write && !w_a_err)
          r_wr[w_a_idx] <= 1'b1;
        if (!w_a_write && !w_a_err)
          r_prdata <= w_rd_a[w_a_idx];
      end
    end
  end

  assign prdata    = r_prdata;
  assign pready    = r_pready;
  assign pslverr   = r_pslverr;
  assign reg_wr    = r_wr;
  assign reg_wdata = r_wdata;

endmodule

// File: tb/tb_apb_reg_frontend.sv
// Scoreboard bench: two front ends (RD_WAIT 0 / 3) on
// separate APB buses, each backed by a register model.
module tb_apb_reg_frontend;

  localparam int N = 16;
  localparam logic [N-1:0] RO [2] = '{16'h0004, 16'h0000};
  localparam int RDW [2] = '{0, 3};

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] prdata;
    logic [N-1:0] wr;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          psel    [2];
  logic          penable [2];
  logic          pwrite  [2];
  logic [11:0]   paddr   [2];
  logic [31:0]   pwdata  [2];
  logic [3:0]    pstrb   [2];
  logic [31:0]   prdata  [2];
  logic          pready  [2];
  logic          pslverr [2];
  logic [N*32-1:0] cur   [2];
  logic [N-1:0]  wr      [2];
  logic [31:0]   wdata   [2];
  logic [31:0]   mreg    [2][N];

  logic [1:0]    ld_en;
  int            ld_idx;
  logic [31:0]   ld_val;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  for (genvar d = 0; d < 2; d++) begin : g_model
    always_comb begin
      cur[d] = '0;
      for (int i = 0; i < N; i++) cur[d][32*i +: 32] = mreg[d][i];
    end
    always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
        if (ld_en[d] && ld_idx == i) mreg[d][i] <= ld_val;
        else if (wr[d][i])           mreg[d][i] <= wdata[d];
      end
    end
  end

  apb_reg_frontend #(
    .NUM_REGS(N), .ADDR_W(12), .BASE_ADDR(12'h000),
    .RD_WAIT(0), .RO_MASK(16'h0004)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .pstrb(pstrb[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .reg_cur(cur[0]), .reg_rdata(cur[0]),
    .reg_wr(wr[0]), .reg_wdata(wdata[0])
  );

  apb_reg_frontend #(
    .NUM_REGS(N), .ADDR_W(12), .BASE_ADDR(12'h000),
    .RD_WAIT(3), .RO_MASK(16'h0000)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .pstrb(pstrb[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .reg_cur(cur[1]), .reg_rdata(cur[1]),
    .reg_wr(wr[1]), .reg_wdata(wdata[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_merge(input logic [31:0] w,
                                            input logic [3:0] s,
                                            input logic [31:0] c);
    logic [31:0] r;
    r = c;
    if (s[0]) r[7:0]   = w[7:0];
    if (s[1]) r[15:8]  = w[15:8];
    if (s[2]) r[23:16] = w[23:16];
    if (s[3]) r[31:24] = w[31:24];
    return r;
  endfunction

  task automatic poke(input int d, input int i, input logic [31:0] v);
    ld_en[d] = 1'b1; ld_idx = i; ld_val = v;
    @(posedge clk); #1;
    ld_en[d] = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Starts at posedge+1, returns at posedge+1 after completion
  task automatic xfer(input int d, input bit w, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    exp_t g;
    int   idx;
    int   lat;
    idx = int'(a[11:2]);
    e.rd  = !w;
    e.err = (a[1:0] != 2'b00) || (idx >= N) ||
            (w && idx < N && RO[d][idx]);
    e.wr = '0; e.wdata = '0; e.prdata = '0;
    if (!e.err && w) begin
      e.wr[idx] = 1'b1;
      e.wdata = exp_merge(wd, st, mreg[d][idx]);
    end
    if (!e.err && !w) e.prdata = mreg[d][idx];
    e.lat = w ? 1 : 1 + RDW[d];
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = w;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 1;
    forever begin
      @(negedge clk);
      if (pready[d] || lat >= 12) break;
      @(posedge clk); #1;
      lat++;
    end
    g = sb.pop_front();
    check("pready", 32'(pready[d]), 32'd1);
    check("latency", 32'(lat), 32'(g.lat));
    check("pslverr", 32'(pslverr[d]), 32'(g.err));
    check("reg_wr", 32'(wr[d]), 32'(g.wr));
    if (g.rd || g.err) check("prdata", prdata[d], g.prdata);
    if (!g.rd && !g.err) check("reg_wdata", wdata[d], g.wdata);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    check("pready_drop", 32'(pready[d]), 32'd0);
    check("reg_wr_drop", 32'(wr[d]), 32'd0);
    check("prdata_drop", prdata[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rstn = 1'b0;
    ld_en = '0; ld_idx = 0; ld_val = '0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", 32'(pready[d]), 32'd0);
      check("rst_pslverr", 32'(pslverr[d]), 32'd0);
      check("rst_prdata", prdata[d], 32'd0);
      check("rst_reg_wr", 32'(wr[d]), 32'd0);
      check("rst_reg_wdata", wdata[d], 32'd0);
    end
    poke(0, 5, 32'h11223344);
    poke(0, 7, 32'hCAFEF00D);
    poke(1, 7, 32'hCAFEF00D);
    rstn = 1'b1;
    idle();

    xfer(0, 1'b1, 12'h00C, 32'h12345678, 4'hF);
    xfer(0, 1'b1, 12'h014, 32'h0000AB00, 4'b0010);
    check("merge_reg5", mreg[0][5], 32'h1122AB44);
    xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF);
    xfer(1, 1'b0, 12'h01C, 32'h0, 4'hF);
    xfer(0, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF);
    xfer(0, 1'b0, 12'h006, 32'h0, 4'hF);
    xfer(0, 1'b1, 12'h008, 32'h55555555, 4'hF);

    xfer(0, 1'b1, 12'h000, 32'hA5A50F0F, 4'hF);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'hF);
    check("b2b_reg0", mreg[0][0], 32'hA5A50F0F);

    idle();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0;
    paddr[1] = 12'h01C;
    idle();
    penable[1] = 1'b1;
    idle();
    psel[1] = 1'b0; penable[1] = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready[1]) cnt++;
    end
    check("abort_no_pready", 32'(cnt), 32'd0);
    idle();
    xfer(1, 1'b0, 12'h01C, 32'h0, 4'hF);

    idle();
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 12'h010; pwdata[0] = 32'hDEADBEEF; pstrb[0] = 4'hF;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst_pready", 32'(pready[0]), 32'd0);
    check("arst_pslverr", 32'(pslverr[0]), 32'd0);
    check("arst_prdata", prdata[0], 32'd0);
    check("arst_reg_wr", 32'(wr[0]), 32'd0);
    check("arst_reg_wdata", wdata[0], 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr[0] != '0) cnt++;
    end
    check("arst_no_strobe", 32'(cnt), 32'd0);
    psel[0] = 1'b0;
    idle();
    rstn = 1'b1;
    idle();
    xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
